// File: rtl/fp_console_responder_pkg.sv
// Shared types and constants for the front-panel console responder.
package fp_console_responder_pkg;

  localparam int unsigned WORD_W = 12;

  typedef logic [WORD_W-1:0] word_t;

  localparam logic [1:0] DISP_PC = 2'b00;
  localparam logic [1:0] DISP_AC = 2'b01;
  localparam logic [1:0] DISP_MA = 2'b10;
  localparam logic [1:0] DISP_MB = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    DEP_WAIT,
    DEP_INC,
    STEP_WAIT,
    RUN_START,
    RUN_WAIT,
    HALT_P
  } state_e;

  // Deposit transaction latched when the strobe is accepted.
  typedef struct packed {
    word_t addr;
    word_t data;
  } deposit_t;

endpackage

// File: rtl/fp_console_responder_if.sv
// Panel, CPU-core and memory-write signals seen by the console responder.
interface fp_console_responder_if;
  import fp_console_responder_pkg::*;

  logic        run;
  logic        step;
  logic        loadpc;
  logic        loadac;
  logic        deposit;
  word_t       swreg;
  logic [1:0]  dispsel;
  word_t       dispout;
  logic        linkout;
  logic        halt;
  word_t       cpu_pc;
  word_t       cpu_ac;
  word_t       cpu_ma;
  word_t       cpu_mb;
  logic        cpu_link;
  logic        pc_load;
  logic        ac_load;
  word_t       load_value;
  logic        instr_start;
  logic        instr_done;
  logic        hlt_exec;
  logic        mem_req;
  word_t       mem_addr;
  word_t       mem_wdata;
  logic        mem_ack;
  logic        dep_err;

  modport master (
    input  run, step, loadpc, loadac, deposit, swreg, dispsel,
    input  cpu_pc, cpu_ac, cpu_ma, cpu_mb, cpu_link,
    input  instr_done, hlt_exec, mem_ack,
    output dispout, linkout, halt, pc_load, ac_load, load_value,
    output instr_start, mem_req, mem_addr, mem_wdata, dep_err
  );

  modport slave (
    output run, step, loadpc, loadac, deposit, swreg, dispsel,
    output cpu_pc, cpu_ac, cpu_ma, cpu_mb, cpu_link,
    output instr_done, hlt_exec, mem_ack,
    input  dispout, linkout, halt, pc_load, ac_load, load_value,
    input  instr_start, mem_req, mem_addr, mem_wdata, dep_err
  );

endinterface

// File: rtl/fp_disp_mux.sv
// Registered 4:1 display select of CPU registers plus registered link bit.
module fp_disp_mux
  import fp_console_responder_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] dispsel,
  input  word_t      cpu_pc,
  input  word_t      cpu_ac,
  input  word_t      cpu_ma,
  input  word_t      cpu_mb,
  input  logic       cpu_link,
  output word_t      dispout,
  output logic       linkout
);

  word_t sel_c;

  always_comb begin
    sel_c = cpu_pc;
    case (dispsel)
      DISP_PC: sel_c = cpu_pc;
      DISP_AC: sel_c = cpu_ac;
      DISP_MA: sel_c = cpu_ma;
      DISP_MB: sel_c = cpu_mb;
      default: sel_c = cpu_pc;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dispout <= '0;
      linkout <= 1'b0;
    end else begin
      dispout <= sel_c;
      linkout <= cpu_link;
    end
  end

endmodule

// File: rtl/fp_console_responder.sv
// CPU-side front-panel endpoint: sequences PC/AC loads, deposits and
// step/run execution, and returns display word, link and halt pulse.
module fp_console_responder
  import fp_console_responder_pkg::*;
#(
  parameter int unsigned HALT_PULSE  = 1,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  fp_console_responder_if.master bus
);

  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned HP_W  = 4;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  deposit_t         dep_q, dep_d;
  word_t            load_value_q, load_value_d;
  logic             pc_load_q, pc_load_d;
  logic             ac_load_q, ac_load_d;
  logic             instr_start_q, instr_start_d;
  logic             mem_req_q, mem_req_d;
  logic             dep_err_q, dep_err_d;
  logic             halt_q, halt_d;
  word_t            disp_q;
  logic             link_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      tmo_q         <= '0;
      hp_q          <= '0;
      dep_q         <= '0;
      load_value_q  <= '0;
      pc_load_q     <= 1'b0;
      ac_load_q     <= 1'b0;
      instr_start_q <= 1'b0;
      mem_req_q     <= 1'b0;
      dep_err_q     <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      hp_q          <= hp_d;
      dep_q         <= dep_d;
      load_value_q  <= load_value_d;
      pc_load_q     <= pc_load_d;
      ac_load_q     <= ac_load_d;
      instr_start_q <= instr_start_d;
      mem_req_q     <= mem_req_d;
      dep_err_q     <= dep_err_d;
      halt_q        <= halt_d;
    end
  end

  // Next state and next registered outputs; run outranks every strobe.
  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    hp_d          = hp_q;
    dep_d         = dep_q;
    load_value_d  = '0;
    pc_load_d     = 1'b0;
    ac_load_d     = 1'b0;
    instr_start_d = 1'b0;
    mem_req_d     = mem_req_q;
    dep_err_d     = dep_err_q;
    halt_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.run) begin
          state_d = RUN_START;
        end else if (bus.loadpc) begin
          pc_load_d    = 1'b1;
          load_value_d = bus.swreg;
          dep_err_d    = 1'b0;
        end else if (bus.loadac) begin
          ac_load_d    = 1'b1;
          load_value_d = bus.swreg;
          dep_err_d    = 1'b0;
        end else if (bus.deposit) begin
          dep_d     = '{addr: bus.cpu_pc, data: bus.swreg};
          mem_req_d = 1'b1;
          tmo_d     = '0;
          dep_err_d = 1'b0;
          state_d   = DEP_WAIT;
        end else if (bus.step) begin
          instr_start_d = 1'b1;
          dep_err_d     = 1'b0;
          state_d       = STEP_WAIT;
        end
      end
      DEP_WAIT: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = DEP_INC;
        end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          dep_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      DEP_INC: begin
        pc_load_d    = 1'b1;
        load_value_d = dep_q.addr + WORD_W'(1);
        state_d      = IDLE;
      end
      STEP_WAIT: begin
        if (bus.instr_done) begin
          if (bus.hlt_exec) begin
            halt_d  = 1'b1;
            hp_d    = HP_W'(1);
            state_d = HALT_P;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RUN_START: begin
        instr_start_d = 1'b1;
        state_d       = RUN_WAIT;
      end
      RUN_WAIT: begin
        if (bus.instr_done) begin
          if (bus.hlt_exec) begin
            halt_d  = 1'b1;
            hp_d    = HP_W'(1);
            state_d = HALT_P;
          end else if (!bus.run) begin
            state_d = IDLE;
          end else begin
            state_d = RUN_START;
          end
        end
      end
      HALT_P: begin
        if (hp_q == HP_W'(HALT_PULSE)) begin
          state_d = IDLE;
        end else begin
          halt_d = 1'b1;
          hp_d   = hp_q + HP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  fp_disp_mux u_disp (
    .clock    (clock),
    .reset    (reset),
    .dispsel  (bus.dispsel),
    .cpu_pc   (bus.cpu_pc),
    .cpu_ac   (bus.cpu_ac),
    .cpu_ma   (bus.cpu_ma),
    .cpu_mb   (bus.cpu_mb),
    .cpu_link (bus.cpu_link),
    .dispout  (disp_q),
    .linkout  (link_q)
  );

  assign bus.dispout     = disp_q;
  assign bus.linkout     = link_q;
  assign bus.pc_load     = pc_load_q;
  assign bus.ac_load     = ac_load_q;
  assign bus.load_value  = load_value_q;
  assign bus.instr_start = instr_start_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = dep_q.addr;
  assign bus.mem_wdata   = dep_q.data;
  assign bus.dep_err     = dep_err_q;
  assign bus.halt        = halt_q;

endmodule

// File: tb/tb_fp_console_responder.sv
// Randomized bench for fp_console_responder: a cycle-indexed schedule of
// expected outputs is built from each panel command and checked every cycle.
module tb_fp_console_responder;
  import fp_console_responder_pkg::*;

  localparam int unsigned HP   = 3;
  localparam int unsigned TMO  = 4;
  localparam int          MAXC = 8000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;
  bit   rand_cpu = 1'b1;
  int   n_is_seen = 0;
  int   n_h_seen = 0;

  // Expected outputs per cycle number.
  bit              exp_pcl  [MAXC];
  bit              exp_acl  [MAXC];
  bit [WORD_W-1:0] exp_lv   [MAXC];
  bit              exp_is   [MAXC];
  bit              exp_req  [MAXC];
  bit              exp_halt [MAXC];
  bit              exp_derr [MAXC];
  bit [WORD_W-1:0] exp_ma   [MAXC];
  bit [WORD_W-1:0] exp_mw   [MAXC];

  bit              prev_valid = 1'b0;
  logic [1:0]      prev_sel;
  word_t           prev_pc, prev_ac, prev_ma, prev_mb;
  logic            prev_link;

  fp_console_responder_if bus ();

  fp_console_responder #(.HALT_PULSE(HP), .ACK_TIMEOUT(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (reset) begin
      prev_valid <= 1'b0;
    end else begin
      prev_valid <= 1'b1;
      prev_sel   <= bus.dispsel;
      prev_pc    <= bus.cpu_pc;
      prev_ac    <= bus.cpu_ac;
      prev_ma    <= bus.cpu_ma;
      prev_mb    <= bus.cpu_mb;
      prev_link  <= bus.cpu_link;
    end
  end

  always @(negedge clock) begin
    if (bus.instr_start === 1'b1) n_is_seen++;
    if (bus.halt === 1'b1) n_h_seen++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Every-cycle comparison against the schedule and the display model.
  always @(negedge clock) begin
    if (chk_en) begin : cmp
      int c;
      bit [WORD_W-1:0] dexp;
      bit lexp;
      c = cyc;
      dexp = '0;
      lexp = 1'b0;
      if (prev_valid) begin
        case (prev_sel)
          DISP_PC: dexp = prev_pc;
          DISP_AC: dexp = prev_ac;
          DISP_MA: dexp = prev_ma;
          default: dexp = prev_mb;
        endcase
        lexp = prev_link;
      end
      chk("pc_load",     32'(bus.pc_load),     32'(exp_pcl[c]));
      chk("ac_load",     32'(bus.ac_load),     32'(exp_acl[c]));
      chk("load_value",  32'(bus.load_value),  32'(exp_lv[c]));
      chk("instr_start", 32'(bus.instr_start), 32'(exp_is[c]));
      chk("mem_req",     32'(bus.mem_req),     32'(exp_req[c]));
      chk("mem_addr",    32'(bus.mem_addr),    32'(exp_ma[c]));
      chk("mem_wdata",   32'(bus.mem_wdata),   32'(exp_mw[c]));
      chk("dep_err",     32'(bus.dep_err),     32'(exp_derr[c]));
      chk("halt",        32'(bus.halt),        32'(exp_halt[c]));
      chk("dispout",     32'(bus.dispout),     32'(dexp));
      chk("linkout",     32'(bus.linkout),     32'(lexp));
    end
  end

  task automatic fill_derr(input int c, input bit v);
    for (int i = c; i < MAXC; i++) exp_derr[i] = v;
  endtask

  task automatic fill_dep(input int c, input word_t a, input word_t w);
    for (int i = c; i < MAXC; i++) begin
      exp_ma[i] = a;
      exp_mw[i] = w;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    bus.loadpc     = 1'b0;
    bus.loadac     = 1'b0;
    bus.deposit    = 1'b0;
    bus.step       = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.instr_done = 1'b0;
    bus.hlt_exec   = 1'($urandom);
    bus.swreg      = WORD_W'($urandom);
    if (rand_cpu) begin
      bus.cpu_pc   = WORD_W'($urandom);
      bus.cpu_ac   = WORD_W'($urandom);
      bus.cpu_ma   = WORD_W'($urandom);
      bus.cpu_mb   = WORD_W'($urandom);
      bus.cpu_link = 1'($urandom);
      bus.dispsel  = 2'($urandom);
    end
  endtask

  task automatic noise();
    {bus.step, bus.deposit, bus.loadac, bus.loadpc} = 4'($urandom);
  endtask

  // Strobes are already driven in the current (idle) cycle; schedule the
  // expected response and play the memory/CPU side until idle again.
  task automatic issue(input int k_in);
    int n, k, d;
    bit h;
    word_t v, a;
    n = cyc;
    v = bus.swreg;
    if (bus.loadpc) begin
      exp_pcl[n+1] = 1'b1;
      exp_lv[n+1]  = v;
      fill_derr(n + 1, 1'b0);
    end else if (bus.loadac) begin
      exp_acl[n+1] = 1'b1;
      exp_lv[n+1]  = v;
      fill_derr(n + 1, 1'b0);
    end else if (bus.deposit) begin
      a = bus.cpu_pc;
      fill_dep(n + 1, a, v);
      fill_derr(n + 1, 1'b0);
      k = (k_in > 0) ? k_in : int'($urandom_range(1, TMO + 2));
      if (k <= int'(TMO)) begin
        for (int i = 1; i <= k; i++) exp_req[n+i] = 1'b1;
        exp_pcl[n+k+2] = 1'b1;
        exp_lv[n+k+2]  = a + WORD_W'(1);
        for (int j = 1; j <= k; j++) begin
          tick();
          if (j == k) bus.mem_ack = 1'b1;
        end
        tick();
      end else begin
        for (int i = 1; i <= int'(TMO); i++) exp_req[n+i] = 1'b1;
        fill_derr(n + int'(TMO) + 1, 1'b1);
        repeat (TMO) tick();
      end
    end else if (bus.step) begin
      fill_derr(n + 1, 1'b0);
      exp_is[n+1] = 1'b1;
      d = int'($urandom_range(1, 4));
      h = ($urandom_range(0, 2) == 0);
      for (int j = 1; j <= d; j++) begin
        tick();
        noise();
        if (j == d) begin
          bus.instr_done = 1'b1;
          bus.hlt_exec   = h;
        end
      end
      if (h) begin
        for (int i = 1; i <= int'(HP); i++) exp_halt[n+d+i] = 1'b1;
        repeat (HP) tick();
      end
    end
  endtask

  // Continuous run of ninstr instructions, ending on HLT or on run dropping.
  task automatic op_run(input int ninstr, input bit end_hlt);
    int n, s, d, r, m;
    bit last;
    tick();
    bus.run = 1'b1;
    noise();
    n = cyc;
    s = n + 2;
    tick();
    for (int i = 0; i < ninstr; i++) begin
      last = (i == ninstr - 1);
      d = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, d));
      exp_is[s] = 1'b1;
      for (int c = 0; c <= d; c++) begin
        tick();
        noise();
        if (last && !end_hlt && c >= r) bus.run = 1'b0;
        if (c == d) begin
          bus.instr_done = 1'b1;
          bus.hlt_exec   = last && end_hlt;
        end
      end
      m = s + d;
      if (last) begin
        if (end_hlt) begin
          for (int j = 1; j <= int'(HP); j++) exp_halt[m+j] = 1'b1;
          tick();
          bus.run = 1'b0;
          repeat (HP - 1) tick();
        end
      end else begin
        tick();
        s = m + 2;
      end
    end
  endtask

  initial begin
    bus.run = 1'b0; bus.step = 1'b0; bus.loadpc = 1'b0; bus.loadac = 1'b0;
    bus.deposit = 1'b0; bus.swreg = '0; bus.dispsel = '0;
    bus.cpu_pc = '0; bus.cpu_ac = '0; bus.cpu_ma = '0; bus.cpu_mb = '0;
    bus.cpu_link = 1'b0; bus.instr_done = 1'b0; bus.hlt_exec = 1'b0; bus.mem_ack = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_pc_load",     32'(bus.pc_load),     32'd0);
    chk("rst_ac_load",     32'(bus.ac_load),     32'd0);
    chk("rst_load_value",  32'(bus.load_value),  32'd0);
    chk("rst_instr_start", 32'(bus.instr_start), 32'd0);
    chk("rst_mem_req",     32'(bus.mem_req),     32'd0);
    chk("rst_mem_addr",    32'(bus.mem_addr),    32'd0);
    chk("rst_dep_err",     32'(bus.dep_err),     32'd0);
    chk("rst_halt",        32'(bus.halt),        32'd0);
    chk("rst_dispout",     32'(bus.dispout),     32'd0);
    @(posedge clock);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    // loadpc
    tick(); bus.loadpc = 1'b1; bus.swreg = 12'o1234; issue(0);
    tick(); @(negedge clock);
    chk("dir_loadpc_pc_load", 32'(bus.pc_load),     32'd1);
    chk("dir_loadpc_value",   32'(bus.load_value),  32'(12'o1234));
    chk("dir_loadpc_ac_load", 32'(bus.ac_load),     32'd0);
    chk("dir_loadpc_istart",  32'(bus.instr_start), 32'd0);

    // deposit at 7777 with ack three cycles later, PC wraps
    tick(); bus.deposit = 1'b1; bus.cpu_pc = 12'o7777; bus.swreg = 12'o5252; issue(3);
    tick(); @(negedge clock);
    chk("dir_dep_pc_load", 32'(bus.pc_load),    32'd1);
    chk("dir_dep_wrap",    32'(bus.load_value), 32'd0);
    chk("dir_dep_addr",    32'(bus.mem_addr),   32'(12'o7777));
    chk("dir_dep_wdata",   32'(bus.mem_wdata),  32'(12'o5252));
    chk("dir_dep_err",     32'(bus.dep_err),    32'd0);

    // deposit timeout, then loadac clears dep_err
    tick(); bus.deposit = 1'b1; issue(int'(TMO) + 1);
    tick(); @(negedge clock);
    chk("dir_tmo_dep_err", 32'(bus.dep_err), 32'd1);
    chk("dir_tmo_mem_req", 32'(bus.mem_req), 32'd0);
    chk("dir_tmo_pc_load", 32'(bus.pc_load), 32'd0);
    tick(); bus.loadac = 1'b1; bus.swreg = 12'o0777; issue(0);
    tick(); @(negedge clock);
    chk("dir_loadac_ac_load", 32'(bus.ac_load), 32'd1);
    chk("dir_loadac_clear",   32'(bus.dep_err), 32'd0);

    // run: three instructions then HLT
    n_is_seen = 0;
    n_h_seen  = 0;
    op_run(4, 1'b1);
    tick(); tick(); @(negedge clock);
    chk("dir_run_starts", 32'(n_is_seen), 32'd4);
    chk("dir_run_halt",   32'(n_h_seen),  32'(HP));

    // loadpc and step together: only the load
    tick(); bus.loadpc = 1'b1; bus.step = 1'b1; bus.swreg = 12'o0042; issue(0);
    tick(); @(negedge clock);
    chk("dir_prio_pc_load", 32'(bus.pc_load),     32'd1);
    chk("dir_prio_istart",  32'(bus.instr_start), 32'd0);
    tick(); @(negedge clock);
    chk("dir_prio_istart2", 32'(bus.instr_start), 32'd0);

    // display select walk
    rand_cpu = 1'b0;
    tick();
    bus.cpu_pc = 12'd1; bus.cpu_ac = 12'd2; bus.cpu_ma = 12'd3; bus.cpu_mb = 12'd4;
    for (int s = 0; s < 4; s++) begin
      tick(); bus.dispsel = 2'(s);
      tick(); @(negedge clock);
      chk("dir_dispout", 32'(bus.dispout), 32'(s + 1));
    end
    rand_cpu = 1'b1;

    // randomized traffic
    for (int it = 0; it < 300 && cyc < MAXC - 200; it++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 6) begin
        tick();
        {bus.step, bus.deposit, bus.loadac, bus.loadpc} = 4'($urandom_range(1, 15));
        issue(0);
      end else if (sel < 8) begin
        op_run(int'($urandom_range(1, 4)), 1'($urandom));
      end else begin
        tick();
      end
    end
    tick(); tick();

    // asynchronous reset during a deposit and during RUN_WAIT
    chk_en = 1'b0;
    tick(); bus.deposit = 1'b1;
    tick(); @(negedge clock);
    chk("ar_dep_req_before", 32'(bus.mem_req), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("ar_dep_req",  32'(bus.mem_req),  32'd0);
    chk("ar_dep_addr", 32'(bus.mem_addr), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    tick(); bus.run = 1'b1;
    tick(); tick(); @(negedge clock);
    chk("ar_run_istart_before", 32'(bus.instr_start), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("ar_run_istart",  32'(bus.instr_start), 32'd0);
    chk("ar_run_pc_load", 32'(bus.pc_load),     32'd0);
    chk("ar_run_halt",    32'(bus.halt),        32'd0);
    chk("ar_run_mem_req", 32'(bus.mem_req),     32'd0);
    chk("ar_run_dispout", 32'(bus.dispout),     32'd0);
    chk("ar_run_linkout", 32'(bus.linkout),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
